// File: rtl/stopwatch_lap_core.sv
// Stopwatch core: mixed-radix BCD counter with start/stop, lap hold, clear,
// sticky overflow and a multiplexed 7-segment scanner.
module stopwatch_lap_core #(
   parameter int NUM_DIGITS = 4,
   parameter int SEXA       = 1,
   parameter int TICK_DIV   = 100000,
   parameter int SCAN_DIV   = 1000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ena,
   input  logic                    start_stop,
   input  logic                    lap,
   input  logic                    clear,
   output logic [4*NUM_DIGITS-1:0] disp_bcd,
   output logic                    running,
   output logic                    lap_active,
   output logic                    overflow,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an
);
   localparam int CW = 4*NUM_DIGITS;
   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = $clog2(NUM_DIGITS);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;

   state_t              state_reg, state_next;
   logic [PW-1:0]       presc_reg, presc_next;
   logic [CW-1:0]       count_reg, count_next, count_inc;
   logic [CW-1:0]       lap_reg, lap_next;
   logic                lap_active_reg, lap_active_next;
   logic                overflow_reg, overflow_next;
   logic                ss_prev_reg, lap_prev_reg, clr_prev_reg;
   logic [SW-1:0]       scan_cnt_reg;
   logic [IW-1:0]       scan_idx_reg;
   logic [NUM_DIGITS:0] carry;
   logic                tick, ss_edge, lap_edge, clr_edge;
   logic                clr_act, ss_act, lap_act;
   logic [3:0]          scan_digit;

   assign tick     = ena && (state_reg == RUN) && (presc_reg == PW'(TICK_DIV-1));
   assign carry[0] = tick;

   // Ripple carry through the digit chain; radix-6 digits give MM:SS.hh.
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         localparam logic [3:0] DMAX =
            (SEXA != 0 && (gi == 3 || gi == 5 || gi == 7)) ? 4'd5 : 4'd9;
         logic [3:0] d;
         logic       at_max;
         assign d            = count_reg[4*gi +: 4];
         assign at_max       = (d == DMAX);
         assign carry[gi+1]  = carry[gi] & at_max;
         assign count_inc[4*gi +: 4] = !carry[gi] ? d : (at_max ? 4'd0 : d + 4'd1);
      end
   endgenerate

   assign ss_edge  = ena & start_stop & ~ss_prev_reg;
   assign lap_edge = ena & lap & ~lap_prev_reg;
   assign clr_edge = ena & clear & ~clr_prev_reg;

   // Only an edge that would actually do something can mask lower priorities.
   assign clr_act = clr_edge && (state_reg != RUN);
   assign ss_act  = ss_edge && !clr_act;
   assign lap_act = lap_edge && !clr_act && !ss_act &&
                    ((state_reg == RUN) || (state_reg == STOP && lap_active_reg));

   always_comb begin
      state_next      = state_reg;
      presc_next      = presc_reg;
      count_next      = count_reg;
      lap_next        = lap_reg;
      lap_active_next = lap_active_reg;
      overflow_next   = overflow_reg;
      if (ena && state_reg == RUN) begin
         presc_next = tick ? '0 : presc_reg + PW'(1);
         count_next = count_inc;
         if (carry[NUM_DIGITS])
            overflow_next = 1'b1;
      end
      if (clr_act) begin
         state_next      = IDLE;
         count_next      = '0;
         presc_next      = '0;
         lap_active_next = 1'b0;
         overflow_next   = 1'b0;
      end else if (ss_act) begin
         case (state_reg)
            IDLE:    state_next = RUN;
            RUN:     state_next = STOP;
            STOP:    state_next = RUN;
            default: state_next = IDLE;
         endcase
      end else if (lap_act) begin
         if (state_reg == RUN && !lap_active_reg) begin
            lap_next        = count_reg;
            lap_active_next = 1'b1;
         end else begin
            lap_active_next = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         presc_reg      <= '0;
         count_reg      <= '0;
         lap_reg        <= '0;
         lap_active_reg <= 1'b0;
         overflow_reg   <= 1'b0;
         ss_prev_reg    <= 1'b0;
         lap_prev_reg   <= 1'b0;
         clr_prev_reg   <= 1'b0;
         scan_cnt_reg   <= '0;
         scan_idx_reg   <= '0;
      end else begin
         state_reg      <= state_next;
         presc_reg      <= presc_next;
         count_reg      <= count_next;
         lap_reg        <= lap_next;
         lap_active_reg <= lap_active_next;
         overflow_reg   <= overflow_next;
         if (ena) begin
            ss_prev_reg  <= start_stop;
            lap_prev_reg <= lap;
            clr_prev_reg <= clear;
            if (scan_cnt_reg == SW'(SCAN_DIV-1)) begin
               scan_cnt_reg <= '0;
               scan_idx_reg <= (scan_idx_reg == IW'(NUM_DIGITS-1)) ? '0 : scan_idx_reg + IW'(1);
            end else begin
               scan_cnt_reg <= scan_cnt_reg + SW'(1);
            end
         end
      end
   end

   assign disp_bcd   = lap_active_reg ? lap_reg : count_reg;
   assign running    = (state_reg == RUN);
   assign lap_active = lap_active_reg;
   assign overflow   = overflow_reg;
   assign an         = NUM_DIGITS'(1) << scan_idx_reg;
   assign scan_digit = disp_bcd[{scan_idx_reg, 2'b00} +: 4];

   always_comb begin
      case (scan_digit)
         4'd0:    seg = 7'h3F;
         4'd1:    seg = 7'h06;
         4'd2:    seg = 7'h5B;
         4'd3:    seg = 7'h4F;
         4'd4:    seg = 7'h66;
         4'd5:    seg = 7'h6D;
         4'd6:    seg = 7'h7D;
         4'd7:    seg = 7'h07;
         4'd8:    seg = 7'h7F;
         4'd9:    seg = 7'h6F;
         default: seg = 7'h00;
      endcase
   end
endmodule

// File: doc/stopwatch_lap_core.md
# stopwatch_lap_core

Parametrised stopwatch core for the intro-II stopwatch project: mixed-radix BCD time counter with start/stop, lap (split) hold, clear, sticky overflow and a built-in multiplexed 7-segment scanner. It sits between the debounced button logic and the pad outputs of the `tt_um_intro_ii_stopwatch` top level. It generalises the fixed 4-digit design to N digits and an optional minutes/seconds radix mode.

## Interface

- `NUM_DIGITS`, 4: number of BCD digits, 2..8.
- `SEXA`, 1: 1 = digits 3, 5, 7 count radix 6 (MM:SS.hh); 0 = all decimal.
- `TICK_DIV`, 100000: clk cycles per LSD increment (≥2).
- `SCAN_DIV`, 1000: clk cycles per display digit (≥1).

- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: high = block active; low = freeze all state.
- `start_stop` in 1: synchronous debounced level; acts on rising edge.
- `lap` in 1: synchronous level; acts on rising edge.
- `clear` in 1: synchronous level; acts on rising edge.
- `disp_bcd` out 4*NUM_DIGITS: displayed value, digit 0 in [3:0].
- `running` out 1: state == RUN.
- `lap_active` out 1: display is holding a lap value.
- `overflow` out 1: sticky, set on full-scale wrap.
- `seg` out 7: active-high segments {g,f,e,d,c,b,a} of scanned digit.
- `an` out NUM_DIGITS: one-hot active-high digit enable.

## Operation

- Edge detect: each button has a registered previous value; edge = in & ~prev. Prev registers update only when `ena`=1.
- States IDLE, RUN, STOP. Reset → IDLE.
- Priority for same-cycle edges: clear > start_stop > lap; only the highest-priority valid edge acts, the others are dropped.
- clear: in IDLE or STOP → IDLE, count = 0, prescaler = 0, lap released, overflow = 0. In RUN ignored.
- start_stop: IDLE→RUN, RUN→STOP, STOP→RUN.
- lap: in RUN toggles hold. Hold on: copy live count into lap register. Hold off: release. In STOP releases hold if active, else ignored. In IDLE ignored.
- `disp_bcd` = lap register when `lap_active`, else live count.
- Prescaler counts 0..TICK_DIV-1 only in RUN. At TICK_DIV-1 it issues a tick and returns to 0. It holds its value in STOP, so a fractional tick resumes.
- Tick increments digit 0. Digit i carries when it reaches its max: 9, or 5 for radix-6 digits. At all-max (e.g. 59.99), it wraps to all-zero and sets `overflow`.
- `ena`=0: state, prescaler, counters, lap and scan all hold. Outputs hold.
- Scanner: free-running counter 0..SCAN_DIV-1 in every state. At wrap, the digit index advances 0..NUM_DIGITS-1 cyclically. `an` = 1<<index; `seg` = decode(digit[index] of `disp_bcd`), with 0→7'h3F … 9→7'h6F.
- Reset values: `disp_bcd`=0, `running`=0, `lap_active`=0, `overflow`=0, `an`=1, `seg`=7'h3F. All internal counters = 0, prev registers = 0.

## Timing

- Button rising edge sampled at cycle n → state/lap/clear effect is visible on outputs at cycle n+1.
- Entering RUN at cycle n → first tick after TICK_DIV prescaler cycles. `disp_bcd` increments one cycle after the prescaler's TICK_DIV-1 cycle.
- Lap capture takes the live count of the same cycle as the edge. If a tick coincides, the pre-increment value is captured.
- Scan digit changes every SCAN_DIV cycles. `seg` follows `disp_bcd` combinationally within the scanned digit.
- Async reset mid-count returns to IDLE immediately. No lap or overflow state survives.

## Test plan

Bench parameters: NUM_DIGITS=4, SEXA=1, TICK_DIV=4, SCAN_DIV=2.

1. Reset asserted, then released → `disp_bcd`=16'h0000, `running`=0, `an`=4'b0001, `seg`=7'h3F. `an` becomes 4'b0010 after 2 cycles.
2. start_stop pulse, run 40 cycles, start_stop pulse → `disp_bcd`=16'h0010, `running`=0. Value is stable for 20 more cycles. Restart resumes from the held prescaler value.
3. Run until 16'h5999, then one further tick → `disp_bcd`=16'h0000, `overflow`=1. Stop then clear → `overflow`=0.
4. In RUN at 16'h0012, lap pulse → `lap_active`=1 and display holds 16'h0012 while `running` stays 1. After 8 cycles, second lap pulse → display shows live 16'h0014.
5. clear pulse during RUN → ignored, count keeps advancing. In STOP, clear and start_stop rise on the same cycle → IDLE, `disp_bcd`=0, `running`=0.
6. `ena`=0 for 20 cycles during RUN → `disp_bcd`, `an` and the prescaler are frozen, and a start_stop edge in that window is ignored. With `ena`=1, counting resumes without skipping a tick.
